// File: rtl/stage_buffer_pkg.sv
// Shared constants for the inter-stage buffers: per-stage depths and pointer sizing.
package stage_buffer_pkg;

  localparam int F2D_BUF_DEPTH = 1;
  localparam int D2E_BUF_DEPTH = 2;
  localparam int BUF_DEPTH_MAX = 16;

  // A single-entry buffer still needs a one-bit pointer to index its array.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_buffer.sv
// Circular-queue pipeline buffer between two CPU stages, valid/rdy on both sides,
// with flush, halt gating, occupancy count and an optional registered-ready mode.
module stage_buffer
  import stage_buffer_pkg::*;
#(
  parameter type T       = logic [31:0],
  parameter int  DEPTH   = 2,
  parameter bit  REG_RDY = 1'b0,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             cpu_halt,
  input  logic             pipe_flush,
  input  logic             in_valid,
  output logic             in_rdy,
  input  T                 in_data,
  output logic             out_valid,
  input  logic             out_rdy,
  output T                 out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_xfer_in;
  logic w_xfer_out;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full = (r_count == FULL_CNT);

  // Pass-through mode lets a full buffer accept when the head leaves in the same cycle.
  generate
    if (REG_RDY) begin : g_reg_rdy
      assign in_rdy = !reset_in && !cpu_halt && !w_full;
    end else begin : g_pass_rdy
      assign in_rdy = !reset_in && !cpu_halt && (!w_full || out_rdy);
    end
  endgenerate

  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count      = r_count;
  assign w_xfer_in  = in_valid && in_rdy;
  assign w_xfer_out = out_valid && out_rdy;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (pipe_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_xfer_in) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_xfer_out) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_xfer_in, w_xfer_out})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SIM_DEBUG
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      assert (r_count <= FULL_CNT);
      if (w_xfer_in) assert (!$isunknown(in_data));
    end
  end
`endif

endmodule

// File: tb/tb_stage_buffer.sv
// Directed bench for stage_buffer: three configurations share one stimulus bus,
// each scenario resets them all and checks the instance it targets.
module tb_stage_buffer;

  logic        clk_in = 1'b0;
  logic        reset_in, cpu_halt, pipe_flush, in_valid, out_rdy;
  logic [31:0] in_data;

  logic        rdy_d2, vld_d2, rdy_d4, vld_d4, rdy_d3, vld_d3;
  logic [31:0] dat_d2, dat_d4, dat_d3;
  logic [1:0]  cnt_d2, cnt_d3;
  logic [2:0]  cnt_d4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  stage_buffer #(.DEPTH(2), .REG_RDY(1'b0)) u_d2 (
    .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_rdy(rdy_d2), .in_data(in_data),
    .out_valid(vld_d2), .out_rdy(out_rdy), .out_data(dat_d2), .count(cnt_d2));

  stage_buffer #(.DEPTH(4), .REG_RDY(1'b1)) u_d4 (
    .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_rdy(rdy_d4), .in_data(in_data),
    .out_valid(vld_d4), .out_rdy(out_rdy), .out_data(dat_d4), .count(cnt_d4));

  stage_buffer #(.DEPTH(3), .REG_RDY(1'b0)) u_d3 (
    .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_rdy(rdy_d3), .in_data(in_data),
    .out_valid(vld_d3), .out_rdy(out_rdy), .out_data(dat_d3), .count(cnt_d3));

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_halt = 1'b0; pipe_flush = 1'b0; in_valid = 1'b0; out_rdy = 1'b0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (cnt_d2 !== 2'd0) $display("FAIL reset_count got %0d want 0", cnt_d2); else n_pass++;
    n_total++; if (vld_d2 !== 1'b0) $display("FAIL reset_valid got %b want 0", vld_d2); else n_pass++;
    in_valid = 1'b1; in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    in_valid = 1'b0; #1;
    n_total++; if (cnt_d2 !== 2'd2) $display("FAIL prefill_count got %0d want 2", cnt_d2); else n_pass++;
    reset_in = 1'b1; out_rdy = 1'b1; #1;
    n_total++; if (rdy_d2 !== 1'b0) $display("FAIL rdy_during_reset got %b want 0", rdy_d2); else n_pass++;
    step();
    reset_in = 1'b0; out_rdy = 1'b0; #1;
    n_total++; if (cnt_d2 !== 2'd0) $display("FAIL midreset_count got %0d want 0", cnt_d2); else n_pass++;
    n_total++; if (vld_d2 !== 1'b0) $display("FAIL midreset_valid got %b want 0", vld_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h0) $display("FAIL midreset_data got %h want 0", dat_d2); else n_pass++;
    n_total++; if (rdy_d2 !== 1'b1) $display("FAIL rdy_after_reset got %b want 1", rdy_d2); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i]; step();
    end
    in_valid = 1'b0; #1;
    n_total++; if (cnt_d4 !== 3'd4) $display("FAIL fill_count got %0d want 4", cnt_d4); else n_pass++;
    n_total++; if (rdy_d4 !== 1'b0) $display("FAIL fill_rdy got %b want 0", rdy_d4); else n_pass++;
    out_rdy = 1'b1; #1;
    n_total++; if (rdy_d4 !== 1'b0) $display("FAIL regrdy_no_pass got %b want 0", rdy_d4); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (vld_d4 !== 1'b1) $display("FAIL drain_valid[%0d] got %b want 1", i, vld_d4); else n_pass++;
      n_total++; if (dat_d4 !== vals[i]) $display("FAIL drain_data[%0d] got %h want %h", i, dat_d4, vals[i]); else n_pass++;
      step();
    end
    n_total++; if (vld_d4 !== 1'b0) $display("FAIL drain_empty got %b want 0", vld_d4); else n_pass++;
  endtask

  task automatic test_pass_through();
    do_reset();
    in_valid = 1'b1; in_data = 32'h01; step();
    in_data = 32'h02; step();
    in_data = 32'h03; out_rdy = 1'b1; #1;
    n_total++; if (rdy_d2 !== 1'b1) $display("FAIL pass_rdy got %b want 1", rdy_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h01) $display("FAIL pass_head got %h want 01", dat_d2); else n_pass++;
    step();
    in_valid = 1'b0; out_rdy = 1'b0; #1;
    n_total++; if (cnt_d2 !== 2'd2) $display("FAIL pass_count got %0d want 2", cnt_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h02) $display("FAIL pass_next got %h want 02", dat_d2); else n_pass++;
    out_rdy = 1'b1; step(); #1;
    n_total++; if (dat_d2 !== 32'h03) $display("FAIL pass_third got %h want 03", dat_d2); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i; #1;
      if (i == 0) begin
        n_total++; if (vld_d3 !== 1'b0) $display("FAIL stream_first_valid got %b want 0", vld_d3); else n_pass++;
      end else begin
        n_total++; if (dat_d3 !== 32'h100 + i - 1) $display("FAIL stream_data[%0d] got %h want %h", i, dat_d3, 32'h100 + i - 1); else n_pass++;
        n_total++; if (cnt_d3 !== 2'd1) $display("FAIL stream_count[%0d] got %0d want 1", i, cnt_d3); else n_pass++;
        n_total++; if (rdy_d3 !== 1'b1) $display("FAIL stream_rdy[%0d] got %b want 1", i, rdy_d3); else n_pass++;
      end
      step();
    end
    in_valid = 1'b0; #1;
    n_total++; if (dat_d3 !== 32'h109) $display("FAIL stream_last got %h want 109", dat_d3); else n_pass++;
    step();
    n_total++; if (vld_d3 !== 1'b0) $display("FAIL stream_empty got %b want 0", vld_d3); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'h5; step();
    in_data = 32'h6; step();
    in_data = 32'h7; out_rdy = 1'b1; pipe_flush = 1'b1; #1;
    n_total++; if (rdy_d4 !== 1'b1) $display("FAIL flush_rdy_unmasked got %b want 1", rdy_d4); else n_pass++;
    step();
    pipe_flush = 1'b0; in_valid = 1'b0; out_rdy = 1'b0; #1;
    n_total++; if (cnt_d4 !== 3'd0) $display("FAIL flush_count got %0d want 0", cnt_d4); else n_pass++;
    n_total++; if (vld_d4 !== 1'b0) $display("FAIL flush_valid got %b want 0", vld_d4); else n_pass++;
    step(); step();
    n_total++; if (vld_d4 !== 1'b0) $display("FAIL flush_no_ghost got %b want 0", vld_d4); else n_pass++;
    n_total++; if (dat_d4 !== 32'h0) $display("FAIL flush_data got %h want 0", dat_d4); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    in_valid = 1'b1; in_data = 32'h31; step();
    in_data = 32'h32; step();
    in_data = 32'h33; cpu_halt = 1'b1; out_rdy = 1'b1; #1;
    n_total++; if (rdy_d2 !== 1'b0) $display("FAIL halt_rdy0 got %b want 0", rdy_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h31) $display("FAIL halt_head0 got %h want 31", dat_d2); else n_pass++;
    step();
    n_total++; if (rdy_d2 !== 1'b0) $display("FAIL halt_rdy1 got %b want 0", rdy_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h32) $display("FAIL halt_head1 got %h want 32", dat_d2); else n_pass++;
    n_total++; if (cnt_d2 !== 2'd1) $display("FAIL halt_count1 got %0d want 1", cnt_d2); else n_pass++;
    step();
    n_total++; if (rdy_d2 !== 1'b0) $display("FAIL halt_rdy2 got %b want 0", rdy_d2); else n_pass++;
    n_total++; if (cnt_d2 !== 2'd0) $display("FAIL halt_drained got %0d want 0", cnt_d2); else n_pass++;
    cpu_halt = 1'b0; #1;
    n_total++; if (rdy_d2 !== 1'b1) $display("FAIL release_rdy got %b want 1", rdy_d2); else n_pass++;
    step();
    in_valid = 1'b0; #1;
    n_total++; if (cnt_d2 !== 2'd1) $display("FAIL release_count got %0d want 1", cnt_d2); else n_pass++;
    n_total++; if (dat_d2 !== 32'h33) $display("FAIL release_data got %h want 33", dat_d2); else n_pass++;
  endtask

  initial begin
    reset_in = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_fill_drain();
    test_pass_through();
    test_stream();
    test_flush();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage_buffer.md
Name: stage_buffer

Overview:
Parametrised inter-stage pipeline buffer with a valid/rdy handshake on both sides. It holds DEPTH entries of a generic payload type in a circular queue. It adds pipeline flush, CPU halt gating, an occupancy count and a registered-ready mode. It drops in between any two CPU stages (Fetch/Decode, Decode/Execute, ...) and supersedes the single-entry stage register.

Parameters:
T, logic [31:0], payload type; in the CPU it is one of the stage structs (e.g. DEC_2_EXE)
DEPTH, 2, number of entries; legal range 1..16
REG_RDY, 0, 0 = in_rdy may pass through out_rdy when full; 1 = in_rdy depends only on registered state
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

Ports:
clk_in  input  1  clock; all state changes on the rising edge
reset_in  input  1  synchronous, active-high reset
cpu_halt  input  1  1 = accept no new input; output side keeps draining
pipe_flush  input  1  1 = discard all held entries and any same-cycle input
in_valid  input  1  upstream has data
in_rdy  output  1  buffer can accept data this cycle
in_data  input  $bits(T)  upstream payload
out_valid  output  1  head entry is available
out_rdy  input  1  downstream accepts the head entry
out_data  output  $bits(T)  head entry payload
count  output  CNT_W  number of entries held (0..DEPTH)

Behaviour:
- xfer_in = in_valid & in_rdy; xfer_out = out_valid & out_rdy.
- Reset, synchronous: wr_ptr = 0, rd_ptr = 0, count = 0. After the reset edge: out_valid = 0, out_data = '0, count = 0. in_rdy = 0 while reset_in = 1.
- in_rdy, REG_RDY = 0: !reset_in & !cpu_halt & (count != DEPTH | out_rdy).
- in_rdy, REG_RDY = 1: !reset_in & !cpu_halt & (count != DEPTH).
- out_valid = (count != 0). It is a registered-state function only; there is no combinational path from in_valid.
- out_data = storage[rd_ptr] when out_valid, else '0.
- Latency: data accepted on edge N appears at out_data after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: one transfer per cycle on each side. A simultaneous xfer_in and xfer_out leaves count unchanged, including when full (REG_RDY = 0) and when count = 1.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- count update: +1 on xfer_in only, -1 on xfer_out only, otherwise unchanged.
- Flush, synchronous: when pipe_flush = 1 at an edge, the buffer resets pointers and count to 0. A concurrent xfer_in is discarded; a concurrent xfer_out still counts as consumed downstream. In the next cycle out_valid = 0. in_rdy is not masked by flush.
- cpu_halt: forces in_rdy = 0 only. Held entries continue to drain on out_rdy.
- Priority: reset_in > pipe_flush > normal update.
- Overflow and underflow are impossible by construction, because writes are gated by in_rdy and reads by out_valid. Assertions (SIM_DEBUG) check count <= DEPTH and that in_data has no X when xfer_in.
- DEPTH = 1, REG_RDY = 0 is cycle-identical to the legacy single-entry stage register.

Decomposition:
- Payload structs stay in cpu_structs_pkg.
- Add per-stage depth constants to cpu_params_pkg: F2D_BUF_DEPTH = 1, D2E_BUF_DEPTH = 2.
- No new typedefs are needed; the count width is derived locally.
- Single module; a sub-module is not natural.
- Storage is a plain register array, so no RAM inference is required.

Test Plan:
- Reset mid-stream, DEPTH = 2: fill with 0xA1, 0xA2, assert reset_in for 1 cycle. Required: next cycle count = 0, out_valid = 0, out_data = 0; in_rdy = 0 during reset, 1 after.
- Fill/drain ordering, DEPTH = 4, REG_RDY = 1, out_rdy = 0: write 0x11, 0x22, 0x33, 0x44. Required: count = 4 and in_rdy = 0. Then raise out_rdy: outputs 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, then out_valid = 0.
- Full pass-through, DEPTH = 2, REG_RDY = 0, full with 0x01, 0x02: in_valid = 1 with 0x03, out_rdy = 1. Required: in_rdy = 1, 0x01 consumed, count stays 2, head becomes 0x02.
- Streaming and wrap, DEPTH = 3: stream 0x100..0x109 continuously with out_rdy = 1. Required: in-order output at 1-cycle latency, count constant at 1, pointers wrap three times, no bubble.
- Flush with concurrent write, DEPTH = 4, holding 0x5, 0x6: pipe_flush = 1 while writing 0x7 and out_rdy = 1. Required: next cycle count = 0 and out_valid = 0; 0x7 never appears.
- Halt: cpu_halt = 1 with 2 entries held and out_rdy = 1. Required: in_rdy = 0 throughout and both entries drain. After release, in_rdy = 1 and input is accepted on the following edge.
